// File: rtl/mem_responder.sv
// mem_responder: word-addressed single-port memory slave with programmable wait states and access error flagging.
// Ports: clk, reset (async, active-low) | req/we/addr/wdata request, sampled in IDLE |
//        rdata/err valid while ready pulses | busy high while a request is in flight.
module mem_responder #(
  parameter int          ADDR_W   = 8,
  parameter int          WAIT     = 2,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_we;
  logic              r_bad;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [2**ADDR_W];
  logic              w_bad_in;
  logic              w_commit;
  logic              w_idle;
  logic [ADDR_W-1:0] w_idx;
  logic              w_we;
  logic              w_bad;
  logic [31:0]       w_wdata;
  assign w_bad_in = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
  assign w_idle   = r_state == S_IDLE;
  // With zero wait states the commit happens straight from IDLE, so it uses the live request.
  assign w_commit = reset && ((r_state == S_WAIT && r_cnt == 4'd0) || (w_idle && req && WAIT == 0));
  assign w_idx    = w_idle ? addr[ADDR_W+1:2] : r_idx;
  assign w_we     = w_idle ? we : r_we;
  assign w_bad    = w_idle ? w_bad_in : r_bad;
  assign w_wdata  = w_idle ? wdata : r_wdata;
  always_ff @(posedge clk)
    if (w_commit && w_we && !w_bad) r_mem[w_idx] <= w_wdata;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      r_wdata <= 32'd0;
      rdata   <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= w_commit;
      if (w_commit) begin
        rdata <= w_bad ? ERR_DATA : (w_we ? w_wdata : r_mem[w_idx]);
        err   <= w_bad;
      end
      case (r_state)
        S_IDLE: if (req) begin
          r_idx   <= addr[ADDR_W+1:2];
          r_we    <= we;
          r_wdata <= wdata;
          r_bad   <= w_bad_in;
          r_cnt   <= 4'(WAIT - 1);
          r_state <= (WAIT == 0) ? S_RESP : S_WAIT;
          busy    <= 1'b1;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else r_cnt <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder with WAIT=2 and WAIT=0 instances.
module tb_mem_responder;
  logic        clk = 0;
  logic        reset = 1;
  logic        a_req = 0;
  logic        b_req = 0;
  logic        we = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  typedef struct {logic [31:0] d; logic e; int at;} exp_t;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [31:0] mdl_a [int];
  logic [31:0] mdl_b [int];

  mem_responder #(.ADDR_W(8), .WAIT(2), .ERR_DATA(32'h0)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(a_rdata), .ready(a_ready), .busy(a_busy), .err(a_err));
  mem_responder #(.ADDR_W(8), .WAIT(0), .ERR_DATA(32'h0)) u_b (
    .clk(clk), .reset(reset), .req(b_req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(b_rdata), .ready(b_ready), .busy(b_busy), .err(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (a_ready) begin
      if (qa.size() == 0) chk("a_spurious_ready", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_rdata", a_rdata, ea.d);
        chk("a_err", a_err, ea.e);
        chk("a_latency", cyc, ea.at);
      end
    end

  always @(negedge clk)
    if (b_ready) begin
      if (qb.size() == 0) chk("b_spurious_ready", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_rdata", b_rdata, eb.d);
        chk("b_err", b_err, eb.e);
        chk("b_latency", cyc, eb.at);
      end
    end

  task automatic send(input bit b, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   bad;
    int   k;
    @(negedge clk);
    bad  = (a[1:0] != 2'b00) || (a >= 32'h400);
    k    = int'(a >> 2);
    e.e  = bad;
    e.at = cyc + 1 + (b ? 0 : 2);
    if (b) begin
      e.d = bad ? 32'h0 : (w ? d : mdl_b[k]);
      if (!bad && w) mdl_b[k] = d;
      qb.push_back(e);
    end else begin
      e.d = bad ? 32'h0 : (w ? d : mdl_a[k]);
      if (!bad && w) mdl_a[k] = d;
      qa.push_back(e);
    end
    we = w;
    addr = a;
    wdata = d;
    if (b) b_req = 1;
    else a_req = 1;
    @(negedge clk);
    a_req = 0;
    b_req = 0;
  endtask

  task automatic drain(input bit b, output int cnt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!(b ? b_busy : a_busy)) break;
      cnt++;
      @(negedge clk);
    end
    chk(b ? "b_busy_end" : "a_busy_end", b ? b_busy : a_busy, 0);
    chk(b ? "b_pending" : "a_pending", b ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_err", a_err, 0);
    reset = 1;
    send(0, 1, 32'h10, 32'hCAFE_F00D);
    drain(0, n);
    chk("a_busy_len", n, 3);
    send(0, 0, 32'h10, 0);
    drain(0, n);
    send(0, 1, 32'h12, 32'hFFFF_FFFF);
    drain(0, n);
    send(0, 0, 32'h10, 0);
    drain(0, n);
    send(0, 0, 32'h400, 0);
    drain(0, n);
    send(0, 1, 32'h24, 32'h1111_2222);
    drain(0, n);
    send(0, 1, 32'h20, 32'h3333_4444);
    we = 1;
    addr = 32'h24;
    wdata = 32'hDEAD_BEEF;
    a_req = 1;
    @(negedge clk);
    a_req = 0;
    drain(0, n);
    send(0, 0, 32'h24, 0);
    drain(0, n);
    send(0, 1, 32'h30, 32'h5566_7788);
    drain(0, n);
    @(negedge clk);
    we = 1;
    addr = 32'h30;
    wdata = 32'h9999_9999;
    a_req = 1;
    @(negedge clk);
    a_req = 0;
    chk("a_busy_in_wait", a_busy, 1);
    reset = 0;
    #1;
    chk("mid_rst_rdata", a_rdata, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_err", a_err, 0);
    @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    send(0, 0, 32'h30, 0);
    drain(0, n);
    send(1, 1, 32'h0, 32'h1234_5678);
    drain(1, n);
    send(1, 0, 32'h0, 0);
    drain(1, n);
    chk("b_busy_len", n, 1);
    send(1, 1, 32'h6, 32'hABCD_0000);
    drain(1, n);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
